// File: rtl/gate_truth_table_checker_pkg.sv
// Shared definitions for the gate truth-table checker.
//
// Holds the expected-output tables for the common 2-input gates and the
// checker FSM state encoding. Truth tables are indexed by vector number
// i = {B,A}; bit i is the expected gate output X for that input vector.
//
// Ports: none (package).

package gate_truth_table_checker_pkg;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;

   localparam logic [1:0] LAST_VECTOR = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } state_t;

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// Settle-window timer for the gate truth-table checker.
//
// An 8-bit up-counter. It clears to zero on 'clear' and counts while
// 'enable' is high. 'expire' is high while enabled with the count at
// SETTLE_CYCLES-1, which marks the last settle cycle of a vector.
//
// Ports:
//   CLK    - rising-edge clock
//   RST_N  - asynchronous active-low reset
//   clear  - synchronous clear to zero (has priority over enable)
//   enable - count up by one per clock
//   expire - settle window complete

module gate_truth_table_checker_settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [7:0] LAST_COUNT = 8'(SETTLE_CYCLES - 1);

   logic [7:0] count;

   // Free counter: the FSM holds it cleared outside the settle window, so
   // every vector starts counting from zero.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   assign expire = enable && (count == LAST_COUNT);

endmodule

// File: rtl/gate_truth_table_checker.sv
// Clocked stimulus-and-check stage around a 2-input combinational gate.
//
// On START (while idle) the four input vectors i = 0..3 are driven onto
// A = i[0], B = i[1]. Each vector is held SETTLE_CYCLES cycles, then X is
// sampled for one cycle and compared against GATE_FUNC[i]. After the
// fourth vector, DONE pulses for one cycle and PASS / ERR_CNT / ERR_MASK
// hold the result until the next run starts.
//
// Ports:
//   CLK      - rising-edge clock
//   RST_N    - asynchronous active-low reset
//   START    - level; begins a run when idle, ignored while busy
//   X        - output of the gate being checked (sampled unsynchronised)
//   A, B     - registered gate inputs
//   BUSY     - run in progress
//   DONE     - one-cycle end-of-run pulse
//   PASS     - last run had no mismatches
//   ERR_CNT  - number of mismatching vectors in the last run (0..4)
//   ERR_MASK - bit i set when vector i mismatched

module gate_truth_table_checker
   import gate_truth_table_checker_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [3:0]  GATE_FUNC     = TT_XNOR
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       X,
   output logic       A,
   output logic       B,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [2:0] ERR_CNT,
   output logic [3:0] ERR_MASK
);

   state_t     state;
   state_t     state_next;
   logic [1:0] vec_idx;
   logic [1:0] vec_idx_inc;
   logic       load_first;
   logic       sample_now;
   logic       timer_expire;
   logic       mismatch;
   logic [3:0] mismatch_bit;
   logic [2:0] err_cnt_upd;

   // The timer only runs inside the settle window and sits at zero otherwise.
   gate_truth_table_checker_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .clear  (state != SETTLE),
      .enable (state == SETTLE),
      .expire (timer_expire)
   );

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. START is only looked at in IDLE, which is what makes
   // a mid-run START harmless and lets START in the DONE cycle begin a new run.
   always_comb begin
      state_next = state;
      load_first = 1'b0;
      sample_now = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               state_next = SETTLE;
               load_first = 1'b1;
            end
         end
         SETTLE: begin
            if (timer_expire) begin
               state_next = SAMPLE;
            end
         end
         SAMPLE: begin
            sample_now = 1'b1;
            state_next = (vec_idx == LAST_VECTOR) ? IDLE : SETTLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Comparison of X for the current vector. Case inequality makes an
   // unknown or floating X count as a mismatch. The updated count is formed
   // here so the final PASS includes the last vector's comparison.
   always_comb begin
      vec_idx_inc  = vec_idx + 2'd1;
      mismatch     = (X !== GATE_FUNC[vec_idx]);
      mismatch_bit = 4'({3'b000, mismatch} << vec_idx);
      err_cnt_upd  = ERR_CNT + {2'b00, mismatch};
   end

   // Vector driver and result registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vec_idx  <= 2'd0;
         A        <= 1'b0;
         B        <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         PASS     <= 1'b0;
         ERR_CNT  <= 3'd0;
         ERR_MASK <= 4'd0;
      end else begin
         DONE <= 1'b0;
         if (load_first) begin
            vec_idx  <= 2'd0;
            A        <= 1'b0;
            B        <= 1'b0;
            BUSY     <= 1'b1;
            PASS     <= 1'b0;
            ERR_CNT  <= 3'd0;
            ERR_MASK <= 4'd0;
         end else if (sample_now) begin
            ERR_MASK <= ERR_MASK | mismatch_bit;
            ERR_CNT  <= err_cnt_upd;
            if (vec_idx == LAST_VECTOR) begin
               BUSY <= 1'b0;
               DONE <= 1'b1;
               PASS <= (err_cnt_upd == 3'd0);
            end else begin
               vec_idx <= vec_idx_inc;
               A       <= vec_idx_inc[0];
               B       <= vec_idx_inc[1];
            end
         end
      end
   end

endmodule
